// File: rtl/ripple_cap_pkg.sv
// ----------------------------------------------------------------------------
// ripple_cap_pkg
// Shared definitions for the ripple counter capture block:
//   - default WIDTH / STABLE_CYCLES / EXT_WIDTH values
//   - capture FSM state encoding (ST_IDLE = 1'b0, ST_HOLD = 1'b1)
//   - clog2 helper used to size the stability counter
// ----------------------------------------------------------------------------
package ripple_cap_pkg;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_STABLE_CYCLES = 3;
    localparam int DEF_EXT_WIDTH     = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Ceiling log2; clog2(1) = 0, clog2(3) = 2.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer, one independent chain per bit. No attempt is made
// to keep the bus coherent; the consumer is expected to filter mixed values.
// Ports:
//   clk_i     system clock, rising edge
//   reset_ni  asynchronous, active-low reset (clears both stages)
//   d_i       asynchronous input bus
//   q_o       synchronized bus (2 clk edges of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ripple_count_capture.sv
// ----------------------------------------------------------------------------
// ripple_count_capture
// Brings the bits of an asynchronous ripple counter into the clk domain,
// rejects transient ripple/metastability values with a stability filter,
// presents every settled count once on a valid/ready interface and pulses
// `wrap` when the count goes backwards (15 -> 0 style wrap).
//
// Optional feature macro: RIPPLE_CAP_EXT_EN
//   defined     : an EXT_WIDTH-bit extension counter increments on every wrap
//                 and forms out_count[EXT_WIDTH+WIDTH-1:WIDTH].
//   not defined : upper field of out_count is tied to zero.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   cnt_in     raw ripple counter bits (asynchronous to clk)
//   out_ready  consumer takes out_count when high together with out_valid
//   out_valid  out_count holds an unconsumed settled value
//   out_count  {ext, count}
//   wrap       1-cycle pulse: accepted value < previously accepted value
//   overrun    1-cycle pulse: a pending value was replaced before transfer
// ----------------------------------------------------------------------------
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int EXT_WIDTH     = DEF_EXT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           cnt_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [EXT_WIDTH+WIDTH-1:0] out_count,
    output logic                       wrap,
    output logic                       overrun
);

    localparam int STAB_CLOG = clog2(STABLE_CYCLES);
    localparam int STAB_W    = (STAB_CLOG < 1) ? 1 : STAB_CLOG;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  s_prev_q;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic [WIDTH-1:0]  last_acc_q;
    logic [WIDTH-1:0]  count_q;
    logic              wrap_q;
    logic              overrun_q;
    state_e            state_q;

    logic stable;
    logic accept;
    logic is_wrap;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk_i    (clk),
        .reset_ni (reset),
        .d_i      (cnt_in),
        .q_o      (s)
    );

    // Any change of the synchronized value restarts the stability count.
    always_comb begin
        stab_d = stab_q;
        if (s != s_prev_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 1'b1;
        end
    end

    assign stable  = (stab_q == STAB_MAX) && (s == s_prev_q);
    // Comparing against last_acc makes each settled value accepted only once.
    assign accept  = stable && (s != last_acc_q);
    assign is_wrap = (s < last_acc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_prev_q   <= '0;
            stab_q     <= '0;
            last_acc_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            overrun_q  <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            s_prev_q  <= s;
            stab_q    <= stab_d;
            wrap_q    <= 1'b0;
            overrun_q <= 1'b0;

            case (state_q)
                ST_IDLE: if (accept) state_q <= ST_HOLD;
                // A transfer coinciding with a new accept keeps us in HOLD.
                ST_HOLD: if (out_ready && !accept) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                last_acc_q <= s;
                count_q    <= s;
                wrap_q     <= is_wrap;
                // Latest value wins; only an untaken pending value is an overrun.
                overrun_q  <= (state_q == ST_HOLD) && !out_ready;
            end
        end
    end

`ifdef RIPPLE_CAP_EXT_EN
    logic [EXT_WIDTH-1:0] ext_q;

    // Updates on the same edge as the wrapping value so both appear together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_q <= '0;
        end else if (accept && is_wrap) begin
            ext_q <= ext_q + 1'b1;
        end
    end

    assign out_count = {ext_q, count_q};
`else
    assign out_count = {{EXT_WIDTH{1'b0}}, count_q};
`endif

    assign out_valid = (state_q == ST_HOLD);
    assign wrap      = wrap_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// ----------------------------------------------------------------------------
// tb_ripple_count_capture
// Directed bench for ripple_count_capture (WIDTH=4, STABLE_CYCLES=3,
// EXT_WIDTH=4). Inputs change 1 time unit after a rising edge; a monitor on
// the falling edge counts transfers, wrap and overrun pulses.
// ----------------------------------------------------------------------------
module tb_ripple_count_capture;

    logic       clk;
    logic       reset;
    logic [3:0] cnt_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_count;
    logic       wrap;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int         xfer_cnt = 0;
    logic [7:0] xfer_last = '0;
    int         wrap_cnt = 0;
    logic [7:0] wrap_val = '0;
    int         ovr_cnt = 0;

    int         base_x;
    int         base_w;
    int         base_o;
    logic       found;
    logic [7:0] exp_wrap_val;

    ripple_count_capture #(
        .WIDTH         (4),
        .STABLE_CYCLES (3),
        .EXT_WIDTH     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .wrap      (wrap),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                xfer_cnt  = xfer_cnt + 1;
                xfer_last = out_count;
            end
            if (wrap) begin
                wrap_cnt = wrap_cnt + 1;
                wrap_val = out_count;
            end
            if (overrun) ovr_cnt = ovr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        cnt_in    = 4'h7;
        out_ready = 1'b0;

`ifdef RIPPLE_CAP_EXT_EN
        exp_wrap_val = 8'h10;
`else
        exp_wrap_val = 8'h00;
`endif

        // 1: reset holds outputs low; released value 7 appears within 6 edges
        cycles(4);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(posedge clk); #1;
            if (out_valid) found = 1'b1;
        end
        check("t1_valid_in_6", 32'(found), 32'd1);
        check("t1_count", 32'(out_count), 32'h07);

        // 2: glitch value 4 lasts one cycle and must never be presented
        cnt_in = 4'h0;
        out_ready = 1'b1;
        do_reset();
        cycles(8);
        base_x = xfer_cnt;
        cnt_in = 4'h4;
        cycles(1);
        cnt_in = 4'h5;
        cycles(12);
        check("t2_xfers", 32'(xfer_cnt - base_x), 32'd1);
        check("t2_value", 32'(xfer_last), 32'h05);
        check("t2_valid_after", 32'(out_valid), 32'd0);

        // 3: overwrite while not ready -> one overrun, latest value kept
        out_ready = 1'b0;
        cnt_in = 4'h0;
        do_reset();
        base_o = ovr_cnt;
        base_x = xfer_cnt;
        cnt_in = 4'h3;
        cycles(8);
        cnt_in = 4'h4;
        cycles(8);
        check("t3_overruns", 32'(ovr_cnt - base_o), 32'd1);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_count", 32'(out_count), 32'h04);
        out_ready = 1'b1;
        cycles(3);
        check("t3_xfers", 32'(xfer_cnt - base_x), 32'd1);
        check("t3_xfer_val", 32'(xfer_last), 32'h04);

        // 4: 14,15,0 -> single wrap together with value 0
        cnt_in = 4'h0;
        do_reset();
        base_w = wrap_cnt;
        base_x = xfer_cnt;
        cnt_in = 4'hE;
        cycles(8);
        cnt_in = 4'hF;
        cycles(8);
        cnt_in = 4'h0;
        cycles(8);
        check("t4_wraps", 32'(wrap_cnt - base_w), 32'd1);
        check("t4_wrap_val", 32'(wrap_val), 32'(exp_wrap_val));
        check("t4_xfers", 32'(xfer_cnt - base_x), 32'd3);
        check("t4_last", 32'(xfer_last), 32'(exp_wrap_val));

        // 5: reset in HOLD clears immediately; same value 9 re-presented once
        out_ready = 1'b0;
        cnt_in = 4'h0;
        do_reset();
        cnt_in = 4'h9;
        cycles(8);
        check("t5_valid_pre", 32'(out_valid), 32'd1);
        check("t5_count_pre", 32'(out_count), 32'h09);
        reset = 1'b0;
        #1;
        check("t5_valid_rst", 32'(out_valid), 32'd0);
        cycles(1);
        reset = 1'b1;
        cycles(8);
        check("t5_valid_post", 32'(out_valid), 32'd1);
        check("t5_count_post", 32'(out_count), 32'h09);
        base_x = xfer_cnt;
        out_ready = 1'b1;
        cycles(6);
        check("t5_xfers", 32'(xfer_cnt - base_x), 32'd1);
        check("t5_xfer_val", 32'(xfer_last), 32'h09);

        // 6: ready on the accept edge -> old value moves, new one follows, no overrun
        out_ready = 1'b0;
        cnt_in = 4'h0;
        do_reset();
        cnt_in = 4'h2;
        cycles(8);
        check("t6_hold_2", 32'(out_count), 32'h02);
        base_x = xfer_cnt;
        base_o = ovr_cnt;
        cnt_in = 4'h6;
        cycles(5);
        out_ready = 1'b1;
        cycles(1);
        check("t6_new_count", 32'(out_count), 32'h06);
        check("t6_new_valid", 32'(out_valid), 32'd1);
        check("t6_overrun", 32'(overrun), 32'd0);
        check("t6_xfer_old_n", 32'(xfer_cnt - base_x), 32'd1);
        check("t6_xfer_old_v", 32'(xfer_last), 32'h02);
        cycles(1);
        check("t6_xfer_new_n", 32'(xfer_cnt - base_x), 32'd2);
        check("t6_xfer_new_v", 32'(xfer_last), 32'h06);
        check("t6_valid_end", 32'(out_valid), 32'd0);
        check("t6_overruns", 32'(ovr_cnt - base_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
